// File: rtl/immediate_gen.sv
// Registered RV64I immediate generator: decodes the opcode to an encoding format and
// assembles the sign-extended 64-bit immediate, presented one clock after acceptance.
module immediate_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        in_valid,
  output logic [63:0] out,
  output logic        out_valid,
  output logic [2:0]  fmt,
  output logic        illegal
);

  typedef enum logic [2:0] {
    FmtR   = 3'd0,
    FmtI   = 3'd1,
    FmtS   = 3'd2,
    FmtB   = 3'd3,
    FmtU   = 3'd4,
    FmtJ   = 3'd5,
    FmtUnk = 3'd7
  } fmt_e;

  logic [6:0]  w_opcode;
  logic        w_sign;
  fmt_e        w_fmt;
  logic        w_illegal;
  logic [63:0] w_imm;

  logic [63:0] r_out;
  logic        r_out_valid;
  logic [2:0]  r_fmt;
  logic        r_illegal;

  assign w_opcode = instruction[6:0];
  assign w_sign   = instruction[31];

  // Only the major opcode selects the format; funct3 and register fields are ignored.
  always_comb begin
    w_fmt     = FmtUnk;
    w_illegal = 1'b1;
    unique case (w_opcode)
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b0001111, 7'b1110011: begin
        w_fmt     = FmtI;
        w_illegal = 1'b0;
      end
      7'b0100011: begin
        w_fmt     = FmtS;
        w_illegal = 1'b0;
      end
      7'b1100011: begin
        w_fmt     = FmtB;
        w_illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        w_fmt     = FmtU;
        w_illegal = 1'b0;
      end
      7'b1101111: begin
        w_fmt     = FmtJ;
        w_illegal = 1'b0;
      end
      7'b0110011, 7'b0111011: begin
        w_fmt     = FmtR;
        w_illegal = 1'b0;
      end
      default: begin
        w_fmt     = FmtUnk;
        w_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_imm = 64'd0;
    unique case (w_fmt)
      FmtI: w_imm = {{52{w_sign}}, instruction[31:20]};
      FmtS: w_imm = {{52{w_sign}}, instruction[31:25], instruction[11:7]};
      FmtB: w_imm = {{51{w_sign}}, instruction[31], instruction[7], instruction[30:25],
                     instruction[11:8], 1'b0};
      FmtU: w_imm = {{32{w_sign}}, instruction[31:12], 12'd0};
      FmtJ: w_imm = {{43{w_sign}}, instruction[31], instruction[19:12], instruction[20],
                     instruction[30:21], 1'b0};
      default: w_imm = 64'd0;
    endcase
  end

  // Payload holds its last value while idle; only the valid flag follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= 64'd0;
      r_out_valid <= 1'b0;
      r_fmt       <= 3'd0;
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out     <= w_imm;
        r_fmt     <= w_fmt;
        r_illegal <= w_illegal;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign fmt       = r_fmt;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_immediate_gen.sv
// Scoreboard bench for immediate_gen: directed and random instructions checked against a
// format-level reference model by an independent monitor.
module tb_immediate_gen;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        in_valid;
  logic [63:0] out;
  logic        out_valid;
  logic [2:0]  fmt;
  logic        illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  immediate_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .in_valid    (in_valid),
    .out         (out),
    .out_valid   (out_valid),
    .fmt         (fmt),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] i);
    exp_t              e;
    longint            v;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    int                u32;
    logic signed [20:0] j21;
    i12 = i[31:20];
    s12 = {i[31:25], i[11:7]};
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    u32 = {i[31:12], 12'd0};
    j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    v = 0;
    e.fmt = 3'd7;
    e.ill = 1'b1;
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73: begin v = i12; e.fmt = 3'd1; e.ill = 1'b0; end
      7'h23: begin v = s12; e.fmt = 3'd2; e.ill = 1'b0; end
      7'h63: begin v = b13; e.fmt = 3'd3; e.ill = 1'b0; end
      7'h37, 7'h17: begin v = u32; e.fmt = 3'd4; e.ill = 1'b0; end
      7'h6F: begin v = j21; e.fmt = 3'd5; e.ill = 1'b0; end
      7'h33, 7'h3B: begin v = 0; e.fmt = 3'd0; e.ill = 1'b0; end
      default: v = 0;
    endcase
    e.imm = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic v);
    @(posedge clk);
    #1;
    instruction = instr;
    in_valid    = v;
    if (v) exp_q.push_back(model(instr));
  endtask

  // Monitor: pops on every valid output, otherwise checks that the payload holds.
  initial begin
    exp_t e;
    last_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_exp = '0;
      end else if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("imm", out, e.imm);
          chk("fmt", {61'd0, fmt}, {61'd0, e.fmt});
          chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
          last_exp = e;
        end
      end else begin
        chk("hold_imm", out, last_exp.imm);
        chk("hold_fmt", {61'd0, fmt}, {61'd0, last_exp.fmt});
      end
    end
  end

  logic [31:0] ops [13] = '{32'h03, 32'h13, 32'h1B, 32'h67, 32'h0F, 32'h73, 32'h23,
                            32'h63, 32'h37, 32'h17, 32'h6F, 32'h33, 32'h3B};
  logic [31:0] dir [10] = '{32'h00202183, 32'h001065A3, 32'h003021E7, 32'hFE000EE3,
                            32'h0080006F, 32'h123450B7, 32'h800000B7, 32'h0000007F,
                            32'h00208033, 32'hFFF00013};

  initial begin
    logic [31:0] r;
    int          wait_cyc;
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h800000B7;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", out, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_fmt", {61'd0, fmt}, 64'd0);
      chk("rst_illegal", {63'd0, illegal}, 64'd0);
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b1;

    foreach (dir[k]) drive(dir[k], 1'b1);
    // Valid gating: a load, then an idle cycle with a different word on the bus.
    drive(32'h00202183, 1'b1);
    drive(32'h800000B7, 1'b0);
    drive(32'h0080006F, 1'b0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      if ($urandom_range(0, 5) != 0) r[6:0] = ops[$urandom_range(0, 12)][6:0];
      drive(r, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-stream with one instruction still in flight.
    drive(32'hFE000EE3, 1'b1);
    drive(32'h0000007F, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 64'd0);
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_fmt", {61'd0, fmt}, 64'd0);
    chk("async_rst_illegal", {63'd0, illegal}, 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0080006F, 1'b1);
    drive(32'h0, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
